// File: rtl/lbp_frame_ctrl.sv
// lbp_frame_ctrl: frame-level controller that shares the single-port gray
// image memory between the host loader and the LBP engine, sequences the
// engine's per-frame reset/start, forwards results to the result memory
// and reports frame completion.
//
// Ports:
//   clk, reset             system clock, async active-high reset
//   host_wr_en/addr/wdata  host pixel write port
//   host_start             pulse: image loaded, start processing
//   host_busy, frame_done  frame status to the host
//   gmem_*                 gray memory port (async read data in gmem_rdata)
//   lbp_rst, gray_ready    engine reset and gray memory grant
//   gray_req/addr/data     engine read port
//   lbp_valid/addr/data    engine result strobe, address, data
//   finish                 engine finished flag
//   rmem_*                 result memory write port
//   err                    result check flag (only with LBP_RESULT_CHECK_EN)
//
// Optional feature macro: LBP_RESULT_CHECK_EN adds a result counter and a
// sticky err output flagging a wrong result count or border addresses.

module lbp_frame_ctrl #(
    parameter int AW        = 14,
    parameter int DW        = 8,
    parameter int DRAIN_CYC = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          host_wr_en,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    input  logic          host_start,
    output logic          host_busy,
    output logic          frame_done,
    output logic [AW-1:0] gmem_addr,
    output logic          gmem_we,
    output logic [DW-1:0] gmem_wdata,
    input  logic [DW-1:0] gmem_rdata,
    output logic          lbp_rst,
    output logic          gray_ready,
    input  logic          gray_req,
    input  logic [AW-1:0] gray_addr,
    output logic [DW-1:0] gray_data,
    input  logic          lbp_valid,
    input  logic [AW-1:0] lbp_addr,
    input  logic [DW-1:0] lbp_data,
    input  logic          finish,
`ifdef LBP_RESULT_CHECK_EN
    output logic          err,
`endif
    output logic          rmem_we,
    output logic [AW-1:0] rmem_addr,
    output logic [DW-1:0] rmem_wdata
);

    localparam int CW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] drain_cnt;
    logic [AW-1:0] addr_q;
    logic          host_own;
    logic          in_run;
    logic          fwd_en;
    logic          drain_last;

    assign host_own   = (state == S_IDLE) || (state == S_LOAD);
    assign in_run     = (state == S_RUN);
    assign fwd_en     = (state == S_RUN) || (state == S_DRAIN);
    assign drain_last = (drain_cnt == CW'(DRAIN_CYC - 1));

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (host_start)
                    state_nxt = S_RUN;
                else if (host_wr_en)
                    state_nxt = S_LOAD;
            end
            S_LOAD: begin
                if (host_start)
                    state_nxt = S_RUN;
            end
            S_RUN: begin
                if (finish)
                    state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (drain_last)
                    state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Memory port mux: host writes win while the host owns the memory, the
    // engine drives the address only while requesting in RUN; otherwise the
    // previous address is held.
    always_comb begin
        gmem_we    = host_own && host_wr_en;
        gmem_wdata = gmem_we ? host_wdata : '0;
        if (gmem_we)
            gmem_addr = host_addr;
        else if (in_run && gray_req)
            gmem_addr = gray_addr;
        else
            gmem_addr = addr_q;
        gray_data = in_run ? gmem_rdata : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            drain_cnt  <= '0;
            addr_q     <= '0;
            lbp_rst    <= 1'b1;
            gray_ready <= 1'b0;
            host_busy  <= 1'b0;
            frame_done <= 1'b0;
            rmem_we    <= 1'b0;
            rmem_addr  <= '0;
            rmem_wdata <= '0;
        end else begin
            state      <= state_nxt;
            addr_q     <= gmem_addr;
            drain_cnt  <= (state == S_DRAIN) ? drain_cnt + 1'b1 : '0;
            lbp_rst    <= !((state_nxt == S_RUN) || (state_nxt == S_DRAIN));
            gray_ready <= (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
            host_busy  <= (state_nxt == S_RUN) || (state_nxt == S_DRAIN)
                          || (state_nxt == S_DONE);
            frame_done <= (state_nxt == S_DONE);
            rmem_we    <= fwd_en && lbp_valid;
            if (fwd_en && lbp_valid) begin
                rmem_addr  <= lbp_addr;
                rmem_wdata <= lbp_data;
            end
        end
    end

`ifdef LBP_RESULT_CHECK_EN
    localparam int           HW      = AW / 2;
    localparam logic [13:0]  EXP_CNT = 14'd15876;

    logic [13:0]   res_cnt;
    logic          bad_addr;
    logic          on_border;
    logic [HW-1:0] row;
    logic [HW-1:0] col;

    assign row       = lbp_addr[AW-1:HW];
    assign col       = lbp_addr[HW-1:0];
    assign on_border = (row == '0) || (&row) || (col == '0) || (&col);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_cnt  <= '0;
            bad_addr <= 1'b0;
            err      <= 1'b0;
        end else if (host_own && host_start) begin
            res_cnt  <= '0;
            bad_addr <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (fwd_en && lbp_valid) begin
                res_cnt <= res_cnt + 14'd1;
                if (on_border)
                    bad_addr <= 1'b1;
            end
            if ((state == S_DONE) && ((res_cnt != EXP_CNT) || bad_addr))
                err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_lbp_frame_ctrl.sv
// tb_lbp_frame_ctrl: directed bench for lbp_frame_ctrl with a cycle-level
// reference model of frame timing, memory ownership and result forwarding.

module tb_lbp_frame_ctrl;

    localparam int AW = 14;
    localparam int DW = 8;
    localparam int DC = 2;

    logic          clk;
    logic          reset;
    logic          host_wr_en;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_start;
    logic          host_busy;
    logic          frame_done;
    logic [AW-1:0] gmem_addr;
    logic          gmem_we;
    logic [DW-1:0] gmem_wdata;
    logic [DW-1:0] gmem_rdata;
    logic          lbp_rst;
    logic          gray_ready;
    logic          gray_req;
    logic [AW-1:0] gray_addr;
    logic [DW-1:0] gray_data;
    logic          lbp_valid;
    logic [AW-1:0] lbp_addr;
    logic [DW-1:0] lbp_data;
    logic          finish;
    logic          rmem_we;
    logic [AW-1:0] rmem_addr;
    logic [DW-1:0] rmem_wdata;
`ifdef LBP_RESULT_CHECK_EN
    logic          err;
`endif

    lbp_frame_ctrl #(.AW(AW), .DW(DW), .DRAIN_CYC(DC)) dut (
        .clk        (clk),
        .reset      (reset),
        .host_wr_en (host_wr_en),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_start (host_start),
        .host_busy  (host_busy),
        .frame_done (frame_done),
        .gmem_addr  (gmem_addr),
        .gmem_we    (gmem_we),
        .gmem_wdata (gmem_wdata),
        .gmem_rdata (gmem_rdata),
        .lbp_rst    (lbp_rst),
        .gray_ready (gray_ready),
        .gray_req   (gray_req),
        .gray_addr  (gray_addr),
        .gray_data  (gray_data),
        .lbp_valid  (lbp_valid),
        .lbp_addr   (lbp_addr),
        .lbp_data   (lbp_data),
        .finish     (finish),
`ifdef LBP_RESULT_CHECK_EN
        .err        (err),
`endif
        .rmem_we    (rmem_we),
        .rmem_addr  (rmem_addr),
        .rmem_wdata (rmem_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gray memory seen by the DUT
    logic [DW-1:0] gmem [0:16383] = '{default: 8'h00};
    assign gmem_rdata = gmem[gmem_addr];
    always @(posedge clk) begin
        if (gmem_we)
            gmem[gmem_addr] <= gmem_wdata;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: expected memory contents and frame timeline
    logic [DW-1:0] mem_m [0:16383] = '{default: 8'h00};
    int            c       = 0;
    int            t_start = 0;
    int            t_fin   = -1;
    bit            in_frame = 1'b0;
    logic [AW-1:0] hold_a  = '0;
    bit            pv_valid = 1'b0;
    logic [AW-1:0] pv_addr = '0;
    logic [DW-1:0] pv_data = '0;

    always @(negedge clk) begin : cmp
        bit            run_c;
        bit            drn_c;
        bit            done_c;
        bit            own_c;
        logic [AW-1:0] a_exp;
        if (reset) begin
            chk("rst_lbp_rst", 32'(lbp_rst), 32'd1);
            chk("rst_gray_ready", 32'(gray_ready), 32'd0);
            chk("rst_host_busy", 32'(host_busy), 32'd0);
            chk("rst_frame_done", 32'(frame_done), 32'd0);
            chk("rst_rmem_we", 32'(rmem_we), 32'd0);
`ifdef LBP_RESULT_CHECK_EN
            chk("rst_err", 32'(err), 32'd0);
`endif
            in_frame = 1'b0;
            t_fin    = -1;
            hold_a   = '0;
            pv_valid = 1'b0;
        end else begin
            c++;
            run_c  = in_frame && (c > t_start) && ((t_fin < 0) || (c <= t_fin));
            drn_c  = (t_fin >= 0) && (c > t_fin) && (c <= t_fin + DC);
            done_c = (t_fin >= 0) && (c == t_fin + DC + 1);
            own_c  = !(run_c || drn_c || done_c);

            chk("m_lbp_rst", 32'(lbp_rst), 32'(!(run_c || drn_c)));
            chk("m_gray_ready", 32'(gray_ready), 32'(run_c || drn_c));
            chk("m_frame_done", 32'(frame_done), 32'(done_c));
            if (!done_c)
                chk("m_host_busy", 32'(host_busy), 32'(run_c || drn_c));

            chk("m_rmem_we", 32'(rmem_we), 32'(pv_valid));
            if (pv_valid) begin
                chk("m_rmem_addr", 32'(rmem_addr), 32'(pv_addr));
                chk("m_rmem_wdata", 32'(rmem_wdata), 32'(pv_data));
            end

            chk("m_gmem_we", 32'(gmem_we), 32'(own_c && host_wr_en));
            if (own_c && host_wr_en)
                a_exp = host_addr;
            else if (run_c && gray_req)
                a_exp = gray_addr;
            else
                a_exp = hold_a;
            chk("m_gmem_addr", 32'(gmem_addr), 32'(a_exp));
            if (own_c && host_wr_en)
                chk("m_gmem_wdata", 32'(gmem_wdata), 32'(host_wdata));
            chk("m_gray_data", 32'(gray_data),
                run_c ? 32'(mem_m[a_exp]) : 32'd0);

            if (own_c && host_wr_en)
                mem_m[host_addr] = host_wdata;
            hold_a   = a_exp;
            pv_valid = lbp_valid && (run_c || drn_c);
            pv_addr  = lbp_addr;
            pv_data  = lbp_data;
            if (own_c && host_start) begin
                in_frame = 1'b1;
                t_start  = c;
            end
            if (run_c && finish && (t_fin < 0))
                t_fin = c;
            if (done_c) begin
                in_frame = 1'b0;
                t_fin    = -1;
            end
        end
    end

`ifdef LBP_RESULT_CHECK_EN
    task automatic run_body(input int n);
        int k;
        k = 0;
        for (int r = 1; r <= 126; r++) begin
            for (int cc = 1; cc <= 126; cc++) begin
                if (k < n) begin
                    tick();
                    lbp_valid = 1'b1;
                    lbp_addr  = {r[6:0], cc[6:0]};
                    lbp_data  = k[7:0];
                end
                k++;
            end
        end
        tick(); lbp_valid = 1'b0; finish = 1'b1;
        tick(); finish = 1'b0;
        tick();
        tick();
        tick();
    endtask
`endif

    initial begin
        reset      = 1'b0;
        host_wr_en = 1'b0;
        host_addr  = '0;
        host_wdata = '0;
        host_start = 1'b0;
        gray_req   = 1'b0;
        gray_addr  = '0;
        lbp_valid  = 1'b0;
        lbp_addr   = '0;
        lbp_data   = '0;
        finish     = 1'b0;
        #1 reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        repeat (20) tick();
        @(negedge clk);
        chk("idle_lbp_rst", 32'(lbp_rst), 32'd1);
        chk("idle_gray_ready", 32'(gray_ready), 32'd0);

        // Load three pixels; the last write shares its cycle with host_start
        tick(); host_wr_en = 1'b1; host_addr = 14'h0081; host_wdata = 8'hAB;
        @(negedge clk);
        chk("wr_we", 32'(gmem_we), 32'd1);
        chk("wr_addr", 32'(gmem_addr), 32'h0081);
        chk("wr_data", 32'(gmem_wdata), 32'hAB);
        tick(); host_addr = 14'h0102; host_wdata = 8'h5C;
        tick(); host_addr = 14'h0200; host_wdata = 8'h11; host_start = 1'b1;
        @(negedge clk);
        chk("start_wr_we", 32'(gmem_we), 32'd1);
        tick(); host_wr_en = 1'b0; host_start = 1'b0;
        @(negedge clk);
        chk("run_lbp_rst", 32'(lbp_rst), 32'd0);
        chk("run_gray_ready", 32'(gray_ready), 32'd1);
        chk("run_busy", 32'(host_busy), 32'd1);

        // Engine reads; host write and start in RUN are dropped
        tick(); gray_req = 1'b1; gray_addr = 14'h0102;
        host_wr_en = 1'b1; host_addr = 14'h0005; host_wdata = 8'hEE;
        host_start = 1'b1;
        @(negedge clk);
        chk("rd_data", 32'(gray_data), 32'h5C);
        chk("rd_no_we", 32'(gmem_we), 32'd0);
        chk("rd_addr", 32'(gmem_addr), 32'h0102);
        tick(); host_wr_en = 1'b0; host_start = 1'b0; gray_addr = 14'h0200;
        @(negedge clk);
        chk("rd_same_cyc_wr", 32'(gray_data), 32'h11);
        tick(); gray_req = 1'b0; gray_addr = 14'h0333;
        @(negedge clk);
        chk("rd_hold_addr", 32'(gmem_addr), 32'h0200);
        tick(); gray_req = 1'b1; gray_addr = 14'h0005;
        @(negedge clk);
        chk("rd_dropped_wr", 32'(gray_data), 32'h00);

        // Result forwarding
        tick(); gray_req = 1'b0;
        lbp_valid = 1'b1; lbp_addr = 14'h0081; lbp_data = 8'h3F;
        @(negedge clk);
        chk("fwd_not_yet", 32'(rmem_we), 32'd0);
        tick(); lbp_valid = 1'b0;
        @(negedge clk);
        chk("fwd_we", 32'(rmem_we), 32'd1);
        chk("fwd_addr", 32'(rmem_addr), 32'h0081);
        chk("fwd_data", 32'(rmem_wdata), 32'h3F);

        // finish at T, result at T+1, frame_done at T+DC+1
        tick(); finish = 1'b1;
        tick(); finish = 1'b0;
        lbp_valid = 1'b1; lbp_addr = 14'h0182; lbp_data = 8'h77;
        @(negedge clk);
        chk("t1_done", 32'(frame_done), 32'd0);
        chk("t1_ready", 32'(gray_ready), 32'd1);
        tick(); lbp_valid = 1'b0;
        @(negedge clk);
        chk("t2_fwd_we", 32'(rmem_we), 32'd1);
        chk("t2_fwd_addr", 32'(rmem_addr), 32'h0182);
        chk("t2_fwd_data", 32'(rmem_wdata), 32'h77);
        chk("t2_done", 32'(frame_done), 32'd0);
        tick();
        @(negedge clk);
        chk("t3_done", 32'(frame_done), 32'd1);
        chk("t3_lbp_rst", 32'(lbp_rst), 32'd1);
        chk("t3_ready", 32'(gray_ready), 32'd0);
        tick();
        @(negedge clk);
        chk("t4_done", 32'(frame_done), 32'd0);
        chk("t4_busy", 32'(host_busy), 32'd0);

        // Host owns the memory again; second frame cut by reset
        tick(); host_wr_en = 1'b1; host_addr = 14'h0010; host_wdata = 8'h42;
        @(negedge clk);
        chk("idle2_we", 32'(gmem_we), 32'd1);
        tick(); host_wr_en = 1'b0; host_start = 1'b1;
        tick(); host_start = 1'b0; gray_req = 1'b1; gray_addr = 14'h0010;
        @(negedge clk);
        chk("f2_rd", 32'(gray_data), 32'h42);
        chk("f2_ready", 32'(gray_ready), 32'd1);
        tick(); reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_lbp_rst", 32'(lbp_rst), 32'd1);
        chk("mid_rst_ready", 32'(gray_ready), 32'd0);
        chk("mid_rst_busy", 32'(host_busy), 32'd0);
        chk("mid_rst_gray_data", 32'(gray_data), 32'd0);
        tick(); reset = 1'b0; gray_req = 1'b0;
        repeat (3) tick();

        // Empty load: start straight from IDLE
        tick(); host_start = 1'b1;
        tick(); host_start = 1'b0;
        tick(); finish = 1'b1;
        tick(); finish = 1'b0;
        repeat (6) tick();

`ifdef LBP_RESULT_CHECK_EN
        tick(); host_start = 1'b1;
        tick(); host_start = 1'b0;
        run_body(15875);
        @(negedge clk);
        chk("err_short", 32'(err), 32'd1);
        tick(); host_start = 1'b1;
        @(negedge clk);
        chk("err_sticky", 32'(err), 32'd1);
        tick(); host_start = 1'b0;
        @(negedge clk);
        chk("err_cleared", 32'(err), 32'd0);
        run_body(15876);
        @(negedge clk);
        chk("err_full", 32'(err), 32'd0);
`endif

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
